imem_boot_loader: RTL and testbench
===================================

Name: imem_boot_loader

Overview:
- Writer-side counterpart of the instruction memory's fetch path.
- Receives a program image as a byte stream over a valid/ready handshake, assembles little-endian 32-bit instruction words, and writes them sequentially into instruction memory.
- Asserts out_done_load_inst when the image is complete; the core is held in reset until then.
- Sits between a host byte source (UART RX / debug port / bench driver) and the instruction memory write port.

Parameters:
- ADDR_WIDTH, 64: width of the instruction write address (matches core instruction address width).
- BASE_ADDR, 0: byte address of the first instruction word written.
- MAX_WORDS, 1024: instruction memory capacity in 32-bit words; larger images are rejected.

Ports:
- in_Clk  input  1  system clock, rising-edge.
- Rst  input  1  synchronous, active-high reset.
- in_byte  input  8  incoming image byte.
- in_byte_valid  input  1  in_byte holds a valid byte.
- out_byte_ready  output  1  loader accepts a byte this cycle; transfer occurs when valid && ready.
- out_wr_en  output  1  one-cycle instruction memory write strobe.
- out_wr_addr  output  ADDR_WIDTH  byte address of the word being written.
- out_wr_data  output  32  instruction word being written.
- out_done_load_inst  output  1  image fully written; held until reset.
- out_load_err  output  1  image rejected; held until reset.

Behaviour:
- Reset is synchronous and active-high. While Rst=1 at a clock edge:
  - state<=LEN, byte counter<=0, word counter<=0, length register<=0.
  - All outputs 0 except out_wr_addr=BASE_ADDR.
- Reset asserted mid-load discards the partial word and all counters. Words already written are not erased. out_done_load_inst drops to 0.
- Image format: 4-byte little-endian word count N, then N words, each 4 bytes little-endian (first byte -> bits [7:0]).
- States: LEN, DATA, DONE, ERR (plus CHK, see Optional Feature).
- out_byte_ready is a registered function of state: 1 in LEN/DATA/CHK, 0 in DONE/ERR. Bytes presented in DONE/ERR are never accepted.
- LEN:
  - Accepts 4 bytes into the length register.
  - On the 4th accepted byte:
    - N=0 -> DONE.
    - N>MAX_WORDS -> ERR.
    - Otherwise -> DATA.
- DATA:
  - A 2-bit byte index shifts accepted bytes into a word buffer.
  - On the 4th byte accepted at edge k: at edge k+1 the outputs show out_wr_en=1, out_wr_data=assembled word, out_wr_addr=BASE_ADDR+4*word_index. out_wr_en is 1 for exactly one cycle.
  - The word counter increments with each write. When the counter reaches N, go to DONE in the same cycle the last write strobe is issued.
- Throughput: one byte per cycle sustained. The handshake is not back-pressured by the write, so a word is written every 4 cycles minimum.
- Gaps: in_byte_valid may drop for any number of cycles. The state and partial word are held and no write is issued.
- DONE: out_done_load_inst=1 (registered, asserted the cycle the final strobe is visible, or the cycle after the LEN exit for N=0). Stays in DONE until reset.
- ERR: out_load_err=1, out_done_load_inst=0, no writes. Stays in ERR until reset.
- out_wr_addr arithmetic wraps modulo 2^ADDR_WIDTH. Unreachable within MAX_WORDS for sane BASE_ADDR, and not checked.

Optional Feature:
- Macro: IMEM_BOOT_CHECKSUM_EN.
- Defined:
  - After the N-th word, the loader enters CHK and accepts one extra byte.
  - If that byte equals the XOR of all image bytes (including the 4 length bytes) -> DONE, else -> ERR.
  - With N=0, CHK follows LEN directly.
  - Words are still written as they arrive; a checksum failure does not undo them.
- Undefined: no CHK state. Behaviour is exactly as described above.

Test Plan:
- Rst=1 for 2 cycles, then 0 -> out_byte_ready=1, out_wr_en=0, out_done_load_inst=0, out_wr_addr=0.
- Stream 02 00 00 00, 13 05 10 00, 93 05 20 00, back-to-back, BASE_ADDR=0:
  - Write 0x00100513 @0, then 0x00200593 @4.
  - out_done_load_inst=1 on the second strobe cycle.
  - out_byte_ready=0 afterwards.
- Same image with 3 idle cycles between every byte -> identical writes and addresses, one strobe per word, none during gaps.
- Length 01 04 00 00 (N=1025) with MAX_WORDS=1024 -> out_load_err=1, no out_wr_en ever, done stays 0.
- Length 00 00 00 00 -> no writes, out_done_load_inst=1 the cycle after the 4th byte (macro undefined).
- Rst pulsed after 6 bytes of a 2-word image, then the full image resent:
  - done=0 during reset.
  - Writes restart at address 0.
  - done=1 after the second word.
- With IMEM_BOOT_CHECKSUM_EN and image 01 00 00 00 13 00 00 00:
  - Checksum byte 0x12 -> done=1.
  - Checksum byte 0x00 -> out_load_err=1, with word 0x00000013 still written @0.

Source files
------------

// File: rtl/imem_boot_loader.sv
// imem_boot_loader: receives a program image as a byte stream over valid/ready.
// It assembles little-endian 32-bit words and writes them sequentially into
// instruction memory. out_done_load_inst releases the core once the image is in.
// Image format: 4-byte little-endian word count N, then N little-endian words.
// Optional build macro IMEM_BOOT_CHECKSUM_EN adds one trailing checksum byte.
// That byte is the XOR of every image byte, including the length bytes.
module imem_boot_loader #(
    parameter int unsigned              ADDR_WIDTH = 64,
    parameter logic [ADDR_WIDTH-1:0]    BASE_ADDR  = '0,
    parameter int unsigned              MAX_WORDS  = 1024
) (
    input  logic                  in_Clk,
    input  logic                  Rst,
    input  logic [7:0]            in_byte,
    input  logic                  in_byte_valid,
    output logic                  out_byte_ready,
    output logic                  out_wr_en,
    output logic [ADDR_WIDTH-1:0] out_wr_addr,
    output logic [31:0]           out_wr_data,
    output logic                  out_done_load_inst,
    output logic                  out_load_err
);

    typedef enum logic [2:0] {
        S_LEN,
        S_DATA,
        S_CHK,
        S_DONE,
        S_ERR
    } state_e;

`ifdef IMEM_BOOT_CHECKSUM_EN
    localparam state_e S_END = S_CHK;
`else
    localparam state_e S_END = S_DONE;
`endif

    state_e                  state_q, state_d;
    logic [1:0]              byte_idx_q;
    logic [31:0]             word_cnt_q;
    logic [31:0]             len_q;
    logic [31:0]             word_q;
    logic                    ready_q;
    logic                    wr_en_q;
    logic [ADDR_WIDTH-1:0]   wr_addr_q;
    logic [31:0]             wr_data_q;
    logic                    done_q;
    logic                    err_q;
`ifdef IMEM_BOOT_CHECKSUM_EN
    logic [7:0]              csum_q;
    logic [7:0]              csum_d;
`endif

    logic                    accept;
    logic                    last_byte;
    logic [31:0]             len_d;
    logic [31:0]             word_d;
    logic [31:0]             word_cnt_d;

    // A byte moves only when the host offers it and the loader advertised ready.
    assign accept     = in_byte_valid && ready_q;
    assign last_byte  = (byte_idx_q == 2'd3);
    // Shifting in from the top lands the first byte of each group in bits [7:0].
    assign len_d      = {in_byte, len_q[31:8]};
    assign word_d     = {in_byte, word_q[31:8]};
    assign word_cnt_d = word_cnt_q + 32'd1;
`ifdef IMEM_BOOT_CHECKSUM_EN
    assign csum_d     = csum_q ^ in_byte;
`endif

    // Next-state decision for the load sequence; only accepted bytes advance it.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can leave it unassigned and infer a latch.
        state_d = state_q;
        if (accept) begin
            unique case (state_q)
                S_LEN: begin
                    if (last_byte) begin
                        if (len_d == 32'd0) begin
                            state_d = S_END;
                        end else if (len_d > 32'(MAX_WORDS)) begin
                            state_d = S_ERR;
                        end else begin
                            state_d = S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (last_byte && (word_cnt_d == len_q)) begin
                        state_d = S_END;
                    end
                end
`ifdef IMEM_BOOT_CHECKSUM_EN
                S_CHK: begin
                    state_d = (in_byte == csum_q) ? S_DONE : S_ERR;
                end
`endif
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    // State, counters, word assembly and registered outputs.
    always_ff @(posedge in_Clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (Rst) begin
            state_q    <= S_LEN;
            byte_idx_q <= 2'd0;
            word_cnt_q <= 32'd0;
            len_q      <= 32'd0;
            ready_q    <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= BASE_ADDR;
            wr_data_q  <= 32'd0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
`ifdef IMEM_BOOT_CHECKSUM_EN
            csum_q     <= 8'd0;
`endif
            // NOTE: word_q is deliberately not reset. Clearing byte_idx_q discards any partial word, because stale bytes are shifted out before the next write.
        end else begin
            state_q <= state_d;
            ready_q <= (state_d == S_LEN) || (state_d == S_DATA) || (state_d == S_CHK);
            done_q  <= (state_d == S_DONE);
            err_q   <= (state_d == S_ERR);
            wr_en_q <= 1'b0;
            if (accept) begin
                unique case (state_q)
                    S_LEN: begin
                        len_q      <= len_d;
                        byte_idx_q <= byte_idx_q + 2'd1;
`ifdef IMEM_BOOT_CHECKSUM_EN
                        csum_q     <= csum_d;
`endif
                    end
                    S_DATA: begin
                        word_q     <= word_d;
                        byte_idx_q <= byte_idx_q + 2'd1;
`ifdef IMEM_BOOT_CHECKSUM_EN
                        csum_q     <= csum_d;
`endif
                        if (last_byte) begin
                            wr_en_q    <= 1'b1;
                            wr_data_q  <= word_d;
                            wr_addr_q  <= BASE_ADDR + (ADDR_WIDTH'(word_cnt_q) << 2);
                            word_cnt_q <= word_cnt_d;
                        end
                    end
                    default: begin
                        byte_idx_q <= byte_idx_q;
                    end
                endcase
            end
        end
    end

    assign out_byte_ready     = ready_q;
    assign out_wr_en          = wr_en_q;
    assign out_wr_addr        = wr_addr_q;
    assign out_wr_data        = wr_data_q;
    assign out_done_load_inst = done_q;
    assign out_load_err       = err_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// tb_imem_boot_loader: directed vectors for imem_boot_loader with hand-computed
// expected writes. Inputs are driven and outputs are sampled on the falling edge.
// Build macro IMEM_BOOT_CHECKSUM_EN selects the checksum-image variant.
module tb_imem_boot_loader;

    typedef logic [7:0] byte_q_t[$];

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  in_byte;
    logic        in_byte_valid;
    logic        out_byte_ready;
    logic        out_wr_en;
    logic [63:0] out_wr_addr;
    logic [31:0] out_wr_data;
    logic        out_done_load_inst;
    logic        out_load_err;

    int n_checks = 0;
    int n_errors = 0;
    int stalls   = 0;

    logic [63:0] mon_addr[$];
    logic [31:0] mon_data[$];
    logic        mon_done[$];

    always #5 clk = ~clk;

    imem_boot_loader #(
        .ADDR_WIDTH (64),
        .BASE_ADDR  (64'h0),
        .MAX_WORDS  (1024)
    ) dut (
        .in_Clk             (clk),
        .Rst                (rst),
        .in_byte            (in_byte),
        .in_byte_valid      (in_byte_valid),
        .out_byte_ready     (out_byte_ready),
        .out_wr_en          (out_wr_en),
        .out_wr_addr        (out_wr_addr),
        .out_wr_data        (out_wr_data),
        .out_done_load_inst (out_done_load_inst),
        .out_load_err       (out_load_err)
    );

    // Record every write strobe, with the done flag seen in the same cycle.
    always @(negedge clk) begin
        if (out_wr_en === 1'b1) begin
            mon_addr.push_back(out_wr_addr);
            mon_data.push_back(out_wr_data);
            mon_done.push_back(out_done_load_inst);
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic clear_mon();
        mon_addr.delete();
        mon_data.delete();
        mon_done.delete();
        stalls = 0;
    endtask

    // Hold reset for two edges, check the reset outputs, release, then check ready.
    task automatic do_reset(input string tag);
        rst           = 1'b1;
        in_byte_valid = 1'b0;
        in_byte       = 8'h00;
        @(negedge clk);
        check({tag, "_rst_ready"}, 64'(out_byte_ready), 64'd0);
        check({tag, "_rst_done"},  64'(out_done_load_inst), 64'd0);
        check({tag, "_rst_addr"},  out_wr_addr, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check({tag, "_ready"}, 64'(out_byte_ready), 64'd1);
        clear_mon();
    endtask

    // Called at a falling edge; returns at the falling edge after the byte is taken.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        n             = 0;
        in_byte       = b;
        in_byte_valid = 1'b1;
        while (!out_byte_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!out_byte_ready) stalls++;
        @(negedge clk);
        in_byte_valid = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic send_raw(input byte_q_t img, input int gap);
        foreach (img[i]) send_byte(img[i], gap);
    endtask

    // Send the image; checksum builds append the XOR of every image byte.
    task automatic send_image(input byte_q_t img, input int gap);
        logic [7:0] x;
        x = 8'h00;
        foreach (img[i]) begin
            send_byte(img[i], gap);
            x = x ^ img[i];
        end
`ifdef IMEM_BOOT_CHECKSUM_EN
        send_byte(x, gap);
`endif
    endtask

    task automatic check_write(input string tag, input int idx,
                               input logic [63:0] addr, input logic [31:0] data);
        if (mon_addr.size() > idx) begin
            check({tag, "_addr"}, mon_addr[idx], addr);
            check({tag, "_data"}, 64'(mon_data[idx]), 64'(data));
        end else begin
            check({tag, "_missing"}, 64'(mon_addr.size()), 64'(idx + 1));
        end
    endtask

    // Both writes of the two-word image, the strobe count and the final handshake state.
    task automatic check_two_word(input string tag);
        logic exp_done_at_strobe;
`ifdef IMEM_BOOT_CHECKSUM_EN
        exp_done_at_strobe = 1'b0;
`else
        exp_done_at_strobe = 1'b1;
`endif
        check({tag, "_nwr"}, 64'(mon_addr.size()), 64'd2);
        check_write({tag, "_w0"}, 0, 64'd0, 32'h0010_0513);
        check_write({tag, "_w1"}, 1, 64'd4, 32'h0020_0593);
        if (mon_done.size() == 2) begin
            check({tag, "_done_w0"}, 64'(mon_done[0]), 64'd0);
            check({tag, "_done_w1"}, 64'(mon_done[1]), 64'(exp_done_at_strobe));
        end
        check({tag, "_done"},  64'(out_done_load_inst), 64'd1);
        check({tag, "_ready"}, 64'(out_byte_ready), 64'd0);
        check({tag, "_err"},   64'(out_load_err), 64'd0);
        check({tag, "_stall"}, 64'(stalls), 64'd0);
    endtask

    initial begin
        byte_q_t img2, big, zero, part;
        img2 = {8'h02, 8'h00, 8'h00, 8'h00,
                8'h13, 8'h05, 8'h10, 8'h00,
                8'h93, 8'h05, 8'h20, 8'h00};
        big  = {8'h01, 8'h04, 8'h00, 8'h00};
        zero = {8'h00, 8'h00, 8'h00, 8'h00};
        part = {8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h05};

        rst           = 1'b1;
        in_byte       = 8'h00;
        in_byte_valid = 1'b0;
        @(negedge clk);
        check("init_wr_en", 64'(out_wr_en), 64'd0);
        check("init_err",   64'(out_load_err), 64'd0);

        // Back-to-back two-word image.
        do_reset("t1");
        send_image(img2, 0);
        repeat (3) @(negedge clk);
        check_two_word("t1");

        // Same image with three idle cycles between bytes. Reset must also drop done.
        do_reset("t2");
        send_image(img2, 3);
        repeat (3) @(negedge clk);
        check_two_word("t2");

        // An oversized length is rejected and nothing is written.
        do_reset("t3");
        send_raw(big, 0);
        repeat (4) @(negedge clk);
        check("t3_err",   64'(out_load_err), 64'd1);
        check("t3_done",  64'(out_done_load_inst), 64'd0);
        check("t3_ready", 64'(out_byte_ready), 64'd0);
        check("t3_nwr",   64'(mon_addr.size()), 64'd0);

        // An empty image completes immediately after its last byte.
        do_reset("t4");
        send_image(zero, 0);
        check("t4_done", 64'(out_done_load_inst), 64'd1);
        repeat (2) @(negedge clk);
        check("t4_nwr",   64'(mon_addr.size()), 64'd0);
        check("t4_ready", 64'(out_byte_ready), 64'd0);

        // Reset mid-load, then resend the full image.
        do_reset("t5a");
        send_raw(part, 0);
        check("t5_part_nwr", 64'(mon_addr.size()), 64'd0);
        do_reset("t5b");
        send_image(img2, 0);
        repeat (3) @(negedge clk);
        check_two_word("t5");

`ifdef IMEM_BOOT_CHECKSUM_EN
        // Good checksum, then bad checksum, on a one-word image.
        do_reset("t6a");
        send_raw({8'h01, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00}, 0);
        send_byte(8'h12, 0);
        repeat (2) @(negedge clk);
        check("t6a_done", 64'(out_done_load_inst), 64'd1);
        check("t6a_err",  64'(out_load_err), 64'd0);
        check("t6a_nwr",  64'(mon_addr.size()), 64'd1);
        check_write("t6a_w0", 0, 64'd0, 32'h0000_0013);

        do_reset("t6b");
        send_raw({8'h01, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00}, 0);
        send_byte(8'h00, 0);
        repeat (2) @(negedge clk);
        check("t6b_err",  64'(out_load_err), 64'd1);
        check("t6b_done", 64'(out_done_load_inst), 64'd0);
        check("t6b_nwr",  64'(mon_addr.size()), 64'd1);
        check_write("t6b_w0", 0, 64'd0, 32'h0000_0013);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    // Safety bound so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
